// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  // Master is the operand source / result sink; the adder is the slave.
  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin computed DIGIT bits per clock with a registered carry.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned NCYC = WIDTH / DIGIT;
  localparam int unsigned CNTW = $clog2(NCYC + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NCYC - 1);

  if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic              carry_q, carry_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [DIGIT:0]        digit;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]      sum_sh_next;

  assign digit = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
  // New digit enters at the MSB end so the LSB digit ends up at bit 0 after NCYC steps.
  assign sum_cat     = {digit[DIGIT-1:0], sum_sh_q};
  assign sum_sh_next = sum_cat[WIDTH+DIGIT-1:DIGIT];

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;
  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
  assign msb_cin = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ digit[DIGIT-1];
  assign bus.ovf = ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        carry_d  = digit[DIGIT];
        sum_sh_d = sum_sh_next;
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        count_d  = count_q + CNTW'(1);
        if (count_q == LAST) begin
          sum_d   = sum_sh_next;
          cout_d  = digit[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = msb_cin ^ digit[DIGIT];
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: half-adder, DIGIT=1 and DIGIT=4 builds side by side.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(1)) if_h ();
  serial_adder_if #(.WIDTH(8)) if_1 ();
  serial_adder_if #(.WIDTH(8)) if_4 ();

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_half (.clk(clk), .rst(rst), .bus(if_h.slave));
  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1   (.clk(clk), .rst(rst), .bus(if_1.slave));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4   (.clk(clk), .rst(rst), .bus(if_4.slave));

  int         sel;
  logic [7:0] drv_a, drv_b;
  logic       drv_cin, drv_valid, drv_ready;

  assign if_h.a = drv_a[0:0];
  assign if_h.b = drv_b[0:0];
  assign if_1.a = drv_a;
  assign if_1.b = drv_b;
  assign if_4.a = drv_a;
  assign if_4.b = drv_b;
  assign if_h.cin = drv_cin;
  assign if_1.cin = drv_cin;
  assign if_4.cin = drv_cin;
  assign if_h.in_valid  = drv_valid && (sel == 0);
  assign if_1.in_valid  = drv_valid && (sel == 1);
  assign if_4.in_valid  = drv_valid && (sel == 2);
  assign if_h.out_ready = drv_ready && (sel == 0);
  assign if_1.out_ready = drv_ready && (sel == 1);
  assign if_4.out_ready = drv_ready && (sel == 2);

  logic       o_valid, o_in_ready, o_cout, o_ovf;
  logic [7:0] o_sum;

  always_comb begin
    o_valid = 1'b0; o_in_ready = 1'b0; o_cout = 1'b0; o_ovf = 1'b0; o_sum = '0;
    case (sel)
      0: begin
        o_valid = if_h.out_valid; o_in_ready = if_h.in_ready;
        o_sum = {7'b0, if_h.sum}; o_cout = if_h.cout;
`ifdef SERIAL_ADDER_OVF_EN
        o_ovf = if_h.ovf;
`endif
      end
      1: begin
        o_valid = if_1.out_valid; o_in_ready = if_1.in_ready;
        o_sum = if_1.sum; o_cout = if_1.cout;
`ifdef SERIAL_ADDER_OVF_EN
        o_ovf = if_1.ovf;
`endif
      end
      default: begin
        o_valid = if_4.out_valid; o_in_ready = if_4.in_ready;
        o_sum = if_4.sum; o_cout = if_4.cout;
`ifdef SERIAL_ADDER_OVF_EN
        o_ovf = if_4.ovf;
`endif
      end
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    check_eq("in_ready_idle", o_in_ready, 1);
    drv_a = a; drv_b = b; drv_cin = cin; drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    check_eq("in_ready_run", o_in_ready, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("done_seen", o_valid, 1);
  endtask

  task automatic release_op();
    @(negedge clk);
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    drv_ready = 1'b0;
    check_eq("idle_in_ready", o_in_ready, 1);
    check_eq("idle_out_valid", o_valid, 0);
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] exp_sum, input logic exp_cout,
                       input int exp_lat);
    int lat;
    start_op(a, b, cin);
    wait_done(lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_sum"}, o_sum, exp_sum);
    check_eq({tag, "_cout"}, o_cout, exp_cout);
    release_op();
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    sel = 0;
    drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_eq("rst_in_ready", o_in_ready, 1);
      check_eq("rst_out_valid", o_valid, 0);
      check_eq("rst_sum", o_sum, 0);
      check_eq("rst_cout", o_cout, 0);
      check_eq("rst_ovf", o_ovf, 0);
    end

    // Half-adder equivalence.
    sel = 0;
    do_op("ha00", 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1);
    do_op("ha01", 8'h0, 8'h1, 1'b0, 8'h1, 1'b0, 1);
    do_op("ha10", 8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1);
    do_op("ha11", 8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1);

    sel = 1;
    do_op("d1_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8);
    do_op("d1_cin", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 8);

    sel = 2;
    do_op("d4_a55a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 2);
    do_op("d4_f020", 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 2);

    // Backpressure: result must hold while the sink stalls.
    sel = 1;
    start_op(8'hC8, 8'h64, 1'b0);
    wait_done(lat);
    check_eq("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_out_valid", o_valid, 1);
      check_eq("bp_in_ready", o_in_ready, 0);
      check_eq("bp_sum", o_sum, 8'h2C);
      check_eq("bp_cout", o_cout, 1);
    end
    release_op();
    check_eq("retain_sum", o_sum, 8'h2C);
    check_eq("retain_cout", o_cout, 1);

    // Reset three cycles into RUN discards the operation and clears outputs.
    start_op(8'h55, 8'h22, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_in_ready", o_in_ready, 1);
    check_eq("abort_out_valid", o_valid, 0);
    check_eq("abort_sum", o_sum, 0);
    check_eq("abort_cout", o_cout, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8);

`ifdef SERIAL_ADDER_OVF_EN
    check_eq("ovf_none", o_ovf, 0);
    do_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8);
    check_eq("ovf_pos_ovf", o_ovf, 1);
    do_op("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8);
    check_eq("ovf_neg_ovf", o_ovf, 1);
    sel = 2;
    do_op("ovf_d4", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 2);
    check_eq("ovf_d4_ovf", o_ovf, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
